vec_mod_adder: RTL and testbench

Sequential vector modular adder: computes lane-wise (op0 + op1) mod q over a WLEN-bit word of packed DATA_WIDTH-bit coefficients. It processes one lane per cycle and uses valid/ready handshakes on both sides. It is the addition counterpart to the combinational modular subtractor in the PQ arithmetic datapath, and serves as the add half of NTT butterflies and polynomial additions on wide data registers.

---
 rtl/vec_mod_adder_if.sv | 25 ++
 rtl/vec_mod_adder.sv | 81 ++++++++
 tb/tb_vec_mod_adder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vec_mod_adder_if.sv
// Request/response bundle for the sequential vector modular adder.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
interface vec_mod_adder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int WLEN       = 256
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [WLEN-1:0]       op0_i;
    logic [WLEN-1:0]       op1_i;
    logic [DATA_WIDTH-1:0] q_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [WLEN-1:0]       res_o;

    modport master (
        output in_valid_i, op0_i, op1_i, q_i, out_ready_i,
        input  in_ready_o, out_valid_o, res_o
    );

    modport slave (
        input  in_valid_i, op0_i, op1_i, q_i, out_ready_i,
        output in_ready_o, out_valid_o, res_o
    );
endinterface

// File: rtl/vec_mod_adder.sv
// Lane-serial (op0 + op1) mod q over packed DATA_WIDTH-bit lanes, one lane per cycle.
// Operands and modulus are captured at accept; res_o is the result register itself.
module vec_mod_adder #(
    parameter int DATA_WIDTH = 32,
    parameter int WLEN       = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    vec_mod_adder_if.slave       bus,
    output logic [1:0]           state_dbg_o
);
    localparam int LANES = WLEN / DATA_WIDTH;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [WLEN-1:0]       op0_q, op1_q, res_q;
    logic [DATA_WIDTH-1:0] q_q;

    logic                  accept;
    logic                  last_lane;
    logic [DATA_WIDTH-1:0] lane_a, lane_b, lane_res;
    logic [DATA_WIDTH:0]   sum, q_ext;

    // Datapath for the lane currently selected by the counter.
    always_comb begin
        lane_a   = op0_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
        lane_b   = op1_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
        sum      = {1'b0, lane_a} + {1'b0, lane_b};
        q_ext    = {1'b0, q_q};
        lane_res = (sum >= q_ext) ? DATA_WIDTH'(sum - q_ext) : DATA_WIDTH'(sum);
    end

    assign accept    = (state_q == IDLE) && bus.in_valid_i;
    assign last_lane = (cnt_q == CNT_W'(LANES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid_i) state_d = BUSY;
            BUSY:    if (last_lane) state_d = DONE;
            DONE:    if (bus.out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op0_q   <= '0;
            op1_q   <= '0;
            q_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op0_q <= bus.op0_i;
                op1_q <= bus.op1_i;
                q_q   <= bus.q_i;
                cnt_q <= '0;
                res_q <= '0;
            end else if (state_q == BUSY) begin
                res_q[cnt_q*DATA_WIDTH +: DATA_WIDTH] <= lane_res;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Handshake outputs decode registered state only.
    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.res_o       = res_q;
    assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_vec_mod_adder.sv
// Directed bench for vec_mod_adder with hand-computed lane results.
module tb_vec_mod_adder;
  localparam int DW    = 32;
  localparam int WLEN  = 256;
  localparam int LANES = WLEN / DW;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;

  vec_mod_adder_if #(.DATA_WIDTH(DW), .WLEN(WLEN)) bus ();

  vec_mod_adder #(.DATA_WIDTH(DW), .WLEN(WLEN)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus.slave),
    .state_dbg_o (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WLEN-1:0] obs, input logic [WLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept a vector, check latency, partial and final result, then drain it.
  task automatic run_vec(input string tag, input logic [WLEN-1:0] a, input logic [WLEN-1:0] b,
                         input logic [DW-1:0] q, input logic [WLEN-1:0] exp, input bit scramble);
    logic [WLEN-1:0] lane0_mask;
    lane0_mask = '0;
    lane0_mask[DW-1:0] = '1;
    bus.op0_i = a;
    bus.op1_i = b;
    bus.q_i   = q;
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    chk({tag, "_busy_ready"}, WLEN'(bus.in_ready_o), '0);
    for (int k = 1; k < LANES; k++) begin
      tick();
      if (scramble) begin
        bus.op0_i = {8{$urandom}};
        bus.op1_i = {8{$urandom}};
        bus.q_i   = $urandom;
      end
      chk({tag, "_early_valid"}, WLEN'(bus.out_valid_o), '0);
      if (k == 1) chk({tag, "_partial_lane0"}, bus.res_o, exp & lane0_mask);
    end
    tick();
    chk({tag, "_valid"}, WLEN'(bus.out_valid_o), WLEN'(1));
    chk({tag, "_res"}, bus.res_o, exp);
    chk({tag, "_done_ready"}, WLEN'(bus.in_ready_o), '0);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    chk({tag, "_idle_ready"}, WLEN'(bus.in_ready_o), WLEN'(1));
    chk({tag, "_idle_valid"}, WLEN'(bus.out_valid_o), '0);
    chk({tag, "_res_hold"}, bus.res_o, exp);
  endtask

  logic [WLEN-1:0] hold_res;
  logic [WLEN-1:0] lane_idx;
  logic [WLEN-1:0] three_lanes;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.op0_i = '0;
    bus.op1_i = '0;
    bus.q_i   = '0;
    #3;
    chk("rst_res", bus.res_o, '0);
    chk("rst_ready", WLEN'(bus.in_ready_o), WLEN'(1));
    chk("rst_valid", WLEN'(bus.out_valid_o), '0);
    chk("rst_state", WLEN'(state_dbg), '0);
    tick();
    tick();
    rst = 1'b0;

    // Kyber: 3000+1000=4000-3329=671 in every lane.
    run_vec("kyber", {8{32'd3000}}, {8{32'd1000}}, 32'd3329, {8{32'd671}}, 1'b0);

    // Dilithium q: no reduction, exact q, and max+max lanes.
    run_vec("dil",
      {32'd0, 32'd0, 32'd0, 32'd0, 32'd8380416, 32'd4190208, 32'd1, 32'd0},
      {32'd0, 32'd0, 32'd0, 32'd0, 32'd8380416, 32'd4190209, 32'd2, 32'd0},
      32'd8380417,
      {32'd0, 32'd0, 32'd0, 32'd0, 32'd8380415, 32'd0, 32'd3, 32'd0}, 1'b0);

    // 33-bit sum: 0x1_FFFFFFF4 - 0xFFFFFFFB = 0xFFFFFFF9.
    run_vec("carry", {8{32'hFFFF_FFFA}}, {8{32'hFFFF_FFFA}}, 32'hFFFF_FFFB,
      {8{32'hFFFF_FFF9}}, 1'b0);

    // Backpressure: lanes (k+10) mod 17.
    lane_idx = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    hold_res = {32'd0, 32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10};
    bus.op0_i = lane_idx;
    bus.op1_i = {8{32'd10}};
    bus.q_i   = 32'd17;
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    for (int k = 0; k < LANES; k++) tick();
    chk("bp_valid", WLEN'(bus.out_valid_o), WLEN'(1));
    chk("bp_res", bus.res_o, hold_res);
    bus.op0_i = {8{32'd1}};
    bus.op1_i = {8{32'd1}};
    bus.in_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", WLEN'(bus.out_valid_o), WLEN'(1));
      chk("bp_hold_ready", WLEN'(bus.in_ready_o), '0);
      chk("bp_hold_res", bus.res_o, hold_res);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    chk("bp_release_state", WLEN'(state_dbg), '0);
    chk("bp_release_ready", WLEN'(bus.in_ready_o), WLEN'(1));
    tick();
    tick();
    chk("bp_no_queue_state", WLEN'(state_dbg), '0);
    chk("bp_no_queue_res", bus.res_o, hold_res);

    // Reset after three lanes of the Kyber vector.
    three_lanes = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd671, 32'd671, 32'd671};
    bus.op0_i = {8{32'd3000}};
    bus.op1_i = {8{32'd1000}};
    bus.q_i   = 32'd3329;
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_partial", bus.res_o, three_lanes);
    rst = 1'b1;
    #1;
    chk("mid_rst_res", bus.res_o, '0);
    chk("mid_rst_valid", WLEN'(bus.out_valid_o), '0);
    chk("mid_rst_ready", WLEN'(bus.in_ready_o), WLEN'(1));
    tick();
    rst = 1'b0;
    run_vec("after_rst",
      {32'd0, 32'd0, 32'd0, 32'd0, 32'd8380416, 32'd4190208, 32'd1, 32'd0},
      {32'd0, 32'd0, 32'd0, 32'd0, 32'd8380416, 32'd4190209, 32'd2, 32'd0},
      32'd8380417,
      {32'd0, 32'd0, 32'd0, 32'd0, 32'd8380415, 32'd0, 32'd3, 32'd0}, 1'b0);

    // Isolation: (50+k)+40 mod 97 with inputs scrambled every cycle.
    run_vec("isolate",
      {32'd57, 32'd56, 32'd55, 32'd54, 32'd53, 32'd52, 32'd51, 32'd50},
      {8{32'd40}}, 32'd97,
      {32'd0, 32'd96, 32'd95, 32'd94, 32'd93, 32'd92, 32'd91, 32'd90}, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
